// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the eight requesting units and the mux-select arbiter.
interface mux_sel_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  modport master (output req, input gnt, input sel, input busy);
  modport slave  (input req, output gnt, output sel, output busy);
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for the shared 8:1 mux: registered one-hot grant plus binary select,
// with bounded hold time under contention.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                reset,
  mux_sel_arbiter_if.slave    bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [7:0] hold_cnt, hold_cnt_n;
  logic [7:0] gnt, gnt_n;
  logic [2:0] sel, sel_n;
  logic       busy, busy_n;

  // Returns {found, index} of the first set bit scanning p, p+1, ... p+7 (mod 8).
  function automatic logic [3:0] find_next(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_cnt_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    logic [3:0] win;
    logic       release_owner;
    logic       preempt;
    state_n       = state;
    ptr_n         = ptr;
    hold_cnt_n    = hold_cnt;
    gnt_n         = gnt;
    sel_n         = sel;
    busy_n        = busy;
    win           = '0;
    release_owner = 1'b0;
    preempt       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req != 8'h00) begin
          win        = find_next(bus.req, ptr);
          gnt_n      = 8'b1 << win[2:0];
          sel_n      = win[2:0];
          busy_n     = 1'b1;
          hold_cnt_n = '0;
          state_n    = GRANT;
        end
      end
      GRANT: begin
        // sel doubles as the owner index while a grant is active
        release_owner = !bus.req[sel];
        preempt       = bus.req[sel] && (hold_cnt == HOLD_LAST) && ((bus.req & ~gnt) != 8'h00);
        if (release_owner || preempt) begin
          ptr_n = sel + 3'd1;
          win   = find_next(bus.req, sel + 3'd1);
          if (win[3]) begin
            gnt_n      = 8'b1 << win[2:0];
            sel_n      = win[2:0];
            hold_cnt_n = '0;
          end else begin
            gnt_n   = '0;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else if (hold_cnt != HOLD_LAST) begin
          hold_cnt_n = hold_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.gnt  = gnt;
  assign bus.sel  = sel;
  assign bus.busy = busy;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed vector table, hand sequences, and random traffic
// against an integer-level round-robin model.
module tb_mux_sel_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mux_sel_arbiter_if bus ();
  mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: owner index, cycles owned so far, priority pointer.
  int   m_ptr, m_owner, m_age;
  bit   m_busy;
  logic [2:0] m_sel;

  typedef struct packed {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
  } vec_t;

  vec_t vecs [10];

  function automatic int find_first(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++)
      if (r[(start + k) % 8]) return (start + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_age = 0; m_busy = 0; m_sel = 3'd0;
  endtask

  task automatic model_step(input logic [7:0] r);
    int w;
    bit others;
    if (!m_busy) begin
      if (r != 8'h00) begin
        m_owner = find_first(r, m_ptr);
        m_busy = 1; m_age = 1; m_sel = 3'(m_owner);
      end
    end else begin
      others = (r & ~(8'h01 << m_owner)) != 8'h00;
      if (!r[m_owner] || (others && m_age >= MAX_HOLD)) begin
        m_ptr = (m_owner + 1) % 8;
        w = find_first(r, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_age = 1; m_sel = 3'(w);
        end else begin
          m_busy = 0;
        end
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] g, input logic [2:0] s, input logic b);
    n_checks++;
    if (bus.gnt !== g || bus.sel !== s || bus.busy !== b) begin
      n_errors++;
      $display("FAIL %s @%0t: got gnt=%h sel=%0d busy=%b, expected gnt=%h sel=%0d busy=%b",
               name, $time, bus.gnt, bus.sel, bus.busy, g, s, b);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_busy ? (8'h01 << m_owner) : 8'h00, m_sel, m_busy);
  endtask

  // Drive req, take one clock edge, advance the model, sample 1ns after the edge.
  task automatic cyc(input logic [7:0] r);
    bus.req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    bus.req = 8'h00;
    model_reset();

    vecs[0] = '{8'h04, 8'h04, 3'd2, 1'b1};
    vecs[1] = '{8'h00, 8'h00, 3'd2, 1'b0};
    vecs[2] = '{8'h22, 8'h20, 3'd5, 1'b1};
    vecs[3] = '{8'h02, 8'h02, 3'd1, 1'b1};
    vecs[4] = '{8'h02, 8'h02, 3'd1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 3'd1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 3'd7, 1'b1};
    vecs[7] = '{8'h41, 8'h01, 3'd0, 1'b1};
    vecs[8] = '{8'h00, 8'h00, 3'd0, 1'b0};
    vecs[9] = '{8'h08, 8'h08, 3'd3, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].req);
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy);
    end

    // Sole requester: no rotation, count saturates.
    for (int i = 0; i < 20; i++) begin
      cyc(8'h08);
      check("sole_hold", 8'h08, 3'd3, 1'b1);
    end
    cyc(8'h00);
    check("sole_release", 8'h00, 3'd3, 1'b0);

    // Full contention from reset: each index held exactly MAX_HOLD cycles.
    async_reset();
    model_reset();
    for (int k = 0; k < 8 * MAX_HOLD + 2; k++) begin
      cyc(8'hFF);
      check("rotate", 8'h01 << ((k / MAX_HOLD) % 8), 3'((k / MAX_HOLD) % 8), 1'b1);
    end

    // Reset mid-grant, then first grant after release goes to index 0.
    async_reset();
    cyc(8'hFF);
    check("post_reset_grant", 8'h01, 3'd0, 1'b1);

    // Random traffic against the model, with occasional asynchronous reset.
    model_reset();
    async_reset();
    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: r = 8'h00;
          1: r = 8'h01 << $urandom_range(0, 7);
          2: r = 8'($urandom) & 8'($urandom);
          default: r = 8'($urandom);
        endcase
      end
      cyc(r);
      check_model("random");
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
